// File: rtl/piso_serializer_if.sv
// Handshake and serial-link bundle between an upstream word source, the serializer
// and the downstream deserialiser.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial_out,
        output serial_valid,
        output word_done,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it out
// MSB first, one bit per clock, reloading on the last bit so words stream gap-free.
module piso_serializer #(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    piso_serializer_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_bit;
    logic             ready;
    logic             accept;

    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);
    // Ready depends on state only, so the upstream can chain words into the last-bit slot.
    assign ready    = (state_q == StIdle) || last_bit;
    assign accept   = bus.in_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        sreg_d = bus.in_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready     = ready;
    assign bus.serial_out   = (state_q == StShift) ? sreg_q[WIDTH-1] : 1'b0;
    assign bus.serial_valid = (state_q == StShift);
    assign bus.word_done    = last_bit;
    assign bus.busy         = (state_q == StShift);
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bit stream queued at each accept and
// compared every cycle against the serial output, with a 4-bit SIPO model downstream.
module tb_piso_serializer;
    logic clk;
    logic rst_n;
    logic mon_en;
    int   n_cmp;
    int   n_err;
    logic [1:0] exp_q[$];
    logic [3:0] sipo;
    logic [7:0] w8;

    piso_serializer_if #(.WIDTH(4)) bus4 ();
    piso_serializer_if #(.WIDTH(8)) bus8 ();

    piso_serializer #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    piso_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SIPO: shifts in on valid bits, MSB ends up in bit 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sipo <= 4'b0;
        else if (bus4.serial_valid) sipo <= {sipo[2:0], bus4.serial_out};
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back({w[i], (i == 0)});
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst_n && mon_en) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_b("stream_valid", bus4.serial_valid, 1'b1);
                chk_b("stream_busy", bus4.busy, 1'b1);
                chk_b("stream_bit", bus4.serial_out, e[1]);
                chk_b("stream_done", bus4.word_done, e[0]);
            end else begin
                chk_b("idle_valid", bus4.serial_valid, 1'b0);
                chk_b("idle_busy", bus4.busy, 1'b0);
                chk_b("idle_bit", bus4.serial_out, 1'b0);
                chk_b("idle_done", bus4.word_done, 1'b0);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'b1011;
        bus8.in_valid = 1'b0;
        bus8.in_data  = 8'h00;

        // Reset with valid asserted: no accept, idle outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_b("rst_serial_out", bus4.serial_out, 1'b0);
        chk_b("rst_serial_valid", bus4.serial_valid, 1'b0);
        chk_b("rst_busy", bus4.busy, 1'b0);
        chk_b("rst_word_done", bus4.word_done, 1'b0);
        chk_b("rst_in_ready", bus4.in_ready, 1'b1);
        chk_b("rst8_busy", bus8.busy, 1'b0);
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single word.
        @(posedge clk); #1;
        bus4.in_data = 4'b1011;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        chk_b("idle_ready", bus4.in_ready, 1'b1);
        @(posedge clk);
        push_word(4'b1011);
        #1 bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_w("single_sipo", {4'b0, sipo}, 8'h0B);
        chk_b("single_drained", exp_q.size() == 0, 1'b1);

        // Back-to-back words with valid held high.
        @(posedge clk); #1;
        bus4.in_data = 4'b1011;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        push_word(4'b1011);
        #1 bus4.in_data = 4'b0110;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk_b("b2b_ready_a", bus4.in_ready, c == 4);
            @(posedge clk);
        end
        push_word(4'b0110);
        #1 bus4.in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) chk_w("b2b_sipo_a", {4'b0, sipo}, 8'h0B);
            chk_b("b2b_ready_b", bus4.in_ready, c == 4);
            @(posedge clk);
        end
        @(negedge clk);
        chk_w("b2b_sipo_b", {4'b0, sipo}, 8'h06);
        chk_b("b2b_drained", exp_q.size() == 0, 1'b1);

        // Stall: valid raised mid-word, data changed before the accept.
        @(posedge clk); #1;
        bus4.in_data = 4'b1100;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        push_word(4'b1100);
        #1 bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        bus4.in_valid = 1'b1;
        bus4.in_data = 4'b1110;
        @(negedge clk);
        chk_b("stall_ready_1", bus4.in_ready, 1'b0);
        @(posedge clk); #1;
        bus4.in_data = 4'b0001;
        @(negedge clk);
        chk_b("stall_ready_2", bus4.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_b("stall_ready_3", bus4.in_ready, 1'b1);
        @(posedge clk);
        push_word(4'b0001);
        #1 bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_w("stall_sipo", {4'b0, sipo}, 8'h01);
        chk_b("stall_drained", exp_q.size() == 0, 1'b1);

        // Reset in the middle of a word.
        @(posedge clk); #1;
        bus4.in_data = 4'b1111;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        push_word(4'b1111);
        #1 bus4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        bus4.in_data = 4'b1010;
        bus4.in_valid = 1'b1;
        #1;
        chk_b("midrst_serial_out", bus4.serial_out, 1'b0);
        chk_b("midrst_serial_valid", bus4.serial_valid, 1'b0);
        chk_b("midrst_busy", bus4.busy, 1'b0);
        chk_b("midrst_in_ready", bus4.in_ready, 1'b1);
        @(posedge clk); #1;
        chk_b("midrst_no_accept", bus4.serial_valid, 1'b0);
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        bus4.in_data = 4'b0101;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        push_word(4'b0101);
        #1 bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_w("midrst_sipo", {4'b0, sipo}, 8'h05);
        chk_b("midrst_drained", exp_q.size() == 0, 1'b1);

        // WIDTH=8 instance.
        w8 = 8'hA5;
        @(posedge clk); #1;
        bus8.in_data = w8;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk_b("w8_bit", bus8.serial_out, w8[8 - c]);
                chk_b("w8_done", bus8.word_done, c == 8);
                chk_b("w8_busy", bus8.busy, 1'b1);
                chk_b("w8_valid", bus8.serial_valid, 1'b1);
            end else begin
                chk_b("w8_busy_end", bus8.busy, 1'b0);
                chk_b("w8_valid_end", bus8.serial_valid, 1'b0);
            end
            @(posedge clk);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
